// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Carries the decoder's per-instruction control bundle from ID down through
//   EX, MEM and WB. It also detects load-use hazards (PC and IF/ID stall with
//   a bubble into EX), applies branch flushes, and produces the EX-stage
//   operand forwarding selects from the MEM and WB destinations.
//
//   Optional feature macro: PIPE_PERF_CNT_EN
//     When defined, the block adds stall_cnt and flush_cnt performance
//     counter ports.
//
//   Flow semantics: there is no valid/ready handshake in this block. id_valid
//   qualifies the ID bundle, and the stage registers advance on every clock.
//   Downstream stages are never frozen. Only the PC and IF/ID are held, via
//   pc_write and ifid_write, and ifid_flush requests that IF/ID be cleared.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            id_alusrc,
  input  logic            id_memtoreg,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_branch,
  input  logic [1:0]      id_aluop,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            ex_br_taken,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            ex_alusrc,
  output logic            ex_branch,
  output logic [1:0]      ex_aluop,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic            wb_memtoreg,
  output logic            wb_regwrite,
  output logic [RA_W-1:0] wb_rd
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Forwarding select encodings for the EX operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // EX stage: the full control bundle plus the register fields.
  typedef struct packed {
    logic            alusrc;
    logic            memtoreg;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic [1:0]      aluop;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } ex_stage_t;

  // MEM stage: memory controls plus what WB still needs.
  typedef struct packed {
    logic            memtoreg;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic [RA_W-1:0] rd;
  } mem_stage_t;

  // WB stage: writeback controls and destination.
  typedef struct packed {
    logic            memtoreg;
    logic            regwrite;
    logic [RA_W-1:0] rd;
  } wb_stage_t;

  ex_stage_t  id_bundle;
  ex_stage_t  ex_d;
  ex_stage_t  ex_q;
  mem_stage_t mem_d;
  mem_stage_t mem_q;
  wb_stage_t  wb_d;
  wb_stage_t  wb_q;

  logic load_use;
  logic flush;
  logic stall;
  logic bubble;

  // Forwarding select for one EX source register.
  // The MEM result is the younger value, so it wins over WB.
  // x0 is hard-wired to zero and is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            m_regwrite,
    input logic [RA_W-1:0] m_rd,
    input logic            w_regwrite,
    input logic [RA_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (m_regwrite && (m_rd != '0) && (m_rd == src)) begin
      sel = FWD_MEM;
    end else if (w_regwrite && (w_rd != '0) && (w_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Pack the decoder controls and ID register fields into one EX-shaped bundle.
  always_comb begin
    id_bundle          = '0;
    id_bundle.alusrc   = id_alusrc;
    id_bundle.memtoreg = id_memtoreg;
    id_bundle.regwrite = id_regwrite;
    id_bundle.memread  = id_memread;
    id_bundle.memwrite = id_memwrite;
    id_bundle.branch   = id_branch;
    id_bundle.aluop    = id_aluop;
    id_bundle.rs1      = id_rs1;
    id_bundle.rs2      = id_rs2;
    id_bundle.rd       = id_rd;
  end

  // Hazard detection.
  // A taken branch squashes the instruction in ID, so a flush overrides a
  // concurrent load-use stall. The squashed instruction must not also hold
  // the front end.
  always_comb begin
    load_use = id_valid & ex_q.memread & (ex_q.rd != '0) &
               ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    flush    = ex_br_taken;
    stall    = load_use & ~ex_br_taken;
    bubble   = flush | stall | ~id_valid;
  end

  // Front-end controls are combinational, so the hold and clear act in this same cycle.
  always_comb begin
    pc_write   = ~stall;
    ifid_write = ~stall;
    ifid_flush = flush;
  end

  // Next-state selection for each stage register.
  // A bubble clears every control bit and register field. Only one bubble is
  // needed per load-use, because the load leaves EX on the next edge.
  always_comb begin
    ex_d           = bubble ? '0 : id_bundle;
    mem_d          = '0;
    mem_d.memtoreg = ex_q.memtoreg;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.memread  = ex_q.memread;
    mem_d.memwrite = ex_q.memwrite;
    mem_d.rd       = ex_q.rd;
    wb_d           = '0;
    wb_d.memtoreg  = mem_q.memtoreg;
    wb_d.regwrite  = mem_q.regwrite;
    wb_d.rd        = mem_q.rd;
  end

  // Stage registers advance every cycle. Reset clears all of them, so no
  // stall or flush that is in progress survives a reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // EX operand forwarding selects, from the MEM and WB destinations.
  always_comb begin
    fwd_a = fwd_sel(ex_q.rs1, mem_q.regwrite, mem_q.rd, wb_q.regwrite, wb_q.rd);
    fwd_b = fwd_sel(ex_q.rs2, mem_q.regwrite, mem_q.rd, wb_q.regwrite, wb_q.rd);
  end

  // Registered stage outputs, driven straight from the stage flops.
  always_comb begin
    ex_alusrc    = ex_q.alusrc;
    ex_branch    = ex_q.branch;
    ex_aluop     = ex_q.aluop;
    mem_memread  = mem_q.memread;
    mem_memwrite = mem_q.memwrite;
    wb_memtoreg  = wb_q.memtoreg;
    wb_regwrite  = wb_q.regwrite;
    wb_rd        = wb_q.rd;
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counters: count the cycles spent holding the PC, and the
  // cycles spent flushing IF/ID. Both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ifid_flush) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`else
  // Without the counters, CNT_W has no consumer.
  // This tie-off keeps the parameter referenced.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed testbench for pipe_hazard_ctrl. It drives a linear sequence of
//   steps, each with hand-computed expected values. Inputs change 1 ns after
//   the rising edge, and outputs are sampled 1 ns after that. When
//   PIPE_PERF_CNT_EN is defined, the bench also checks the counters.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 32;

  // Control bundle layout: {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0]}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LW   = 8'b1111_0000;
  localparam logic [7:0] C_ADD  = 8'b0010_0010;
  localparam logic [7:0] C_RW   = 8'b0010_0000;
  localparam logic [7:0] C_SW   = 8'b1000_1000;
  localparam logic [7:0] C_BEQ  = 8'b0000_0101;
  localparam logic [7:0] C_IMM3 = 8'b1010_0011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            id_valid;
  logic            id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
  logic [1:0]      id_aluop;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic            ex_br_taken;
  logic            pc_write, ifid_write, ifid_flush;
  logic            ex_alusrc, ex_branch;
  logic [1:0]      ex_aluop, fwd_a, fwd_b;
  logic            mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite;
  logic [RA_W-1:0] wb_rd;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_alusrc    (id_alusrc),
    .id_memtoreg  (id_memtoreg),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_memwrite  (id_memwrite),
    .id_branch    (id_branch),
    .id_aluop     (id_aluop),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .ex_br_taken  (ex_br_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .ex_alusrc    (ex_alusrc),
    .ex_branch    (ex_branch),
    .ex_aluop     (ex_aluop),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .wb_memtoreg  (wb_memtoreg),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [7:0] c,
                        input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                        input logic [RA_W-1:0] rd);
    id_valid    = v;
    id_alusrc   = c[7];
    id_memtoreg = c[6];
    id_regwrite = c[5];
    id_memread  = c[4];
    id_memwrite = c[3];
    id_branch   = c[2];
    id_aluop    = c[1:0];
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
  endtask

  task automatic idle();
    set_id(1'b0, C_NONE, '0, '0, '0);
    ex_br_taken = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic randomize_inputs();
    set_id(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    ex_br_taken = 1'($urandom_range(0, 1));
  endtask

  // A load followed by a dependent add. This produces exactly one stall cycle.
  task automatic load_use_seq(input logic [RA_W-1:0] rd);
    set_id(1'b1, C_LW, 5'd1, 5'd0, rd);
    tick();
    set_id(1'b1, C_ADD, rd, 5'd0, 5'd6);
    tick();
    tick();
    idle();
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    idle();

    // Reset held low for two clocks while the inputs are random.
    randomize_inputs();
    tick();
    randomize_inputs();
    tick();
    chk("rst_ex_alusrc", 32'(ex_alusrc), 32'd0);
    chk("rst_ex_branch", 32'(ex_branch), 32'd0);
    chk("rst_ex_aluop", 32'(ex_aluop), 32'd0);
    chk("rst_mem_memread", 32'(mem_memread), 32'd0);
    chk("rst_mem_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst_wb_memtoreg", 32'(wb_memtoreg), 32'd0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_pc_write_rand", 32'(pc_write), 32'd1);
    idle();
    settle();
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_ifid_write", 32'(ifid_write), 32'd1);
    chk("rst_ifid_flush", 32'(ifid_flush), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b), 32'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    reset = 1'b1;
    tick();

    // Load-use hazard: lw x5, followed by an add that reads x5.
    set_id(1'b1, C_LW, 5'd2, 5'd0, 5'd5);
    settle();
    chk("lu_pc_write_pre", 32'(pc_write), 32'd1);
    tick();
    set_id(1'b1, C_ADD, 5'd5, 5'd3, 5'd6);
    settle();
    chk("lu_pc_write_stall", 32'(pc_write), 32'd0);
    chk("lu_ifid_write_stall", 32'(ifid_write), 32'd0);
    chk("lu_ifid_flush_stall", 32'(ifid_flush), 32'd0);
    chk("lu_ex_alusrc_lw", 32'(ex_alusrc), 32'd1);
    tick();
    chk("lu_ex_alusrc_bubble", 32'(ex_alusrc), 32'd0);
    chk("lu_ex_aluop_bubble", 32'(ex_aluop), 32'd0);
    chk("lu_mem_memread", 32'(mem_memread), 32'd1);
    chk("lu_pc_write_release", 32'(pc_write), 32'd1);
    chk("lu_ifid_write_release", 32'(ifid_write), 32'd1);
    tick();
    idle();
    settle();
    chk("lu_ex_aluop_add", 32'(ex_aluop), 32'd2);
    chk("lu_fwd_a_wb", 32'(fwd_a), 32'd1);
    chk("lu_fwd_b_rf", 32'(fwd_b), 32'd0);
    chk("lu_wb_memtoreg", 32'(wb_memtoreg), 32'd1);
    chk("lu_wb_regwrite", 32'(wb_regwrite), 32'd1);
    chk("lu_wb_rd", 32'(wb_rd), 32'd5);
    chk("lu_mem_memread_after", 32'(mem_memread), 32'd0);

    // A load whose destination is x0 never stalls.
    drain();
    set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, C_IMM3, 5'd0, 5'd0, 5'd4);
    settle();
    chk("x0_pc_write", 32'(pc_write), 32'd1);
    chk("x0_ifid_write", 32'(ifid_write), 32'd1);
    tick();
    idle();
    settle();
    chk("x0_ex_aluop_passed", 32'(ex_aluop), 32'd3);

    // A branch flush that coincides with a load-use hazard takes priority.
    drain();
    set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd4);
    tick();
    set_id(1'b1, C_BEQ, 5'd0, 5'd4, 5'd0);
    ex_br_taken = 1'b1;
    settle();
    chk("fl_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("fl_pc_write", 32'(pc_write), 32'd1);
    chk("fl_ifid_write", 32'(ifid_write), 32'd1);
    tick();
    idle();
    settle();
    chk("fl_ex_branch_bubble", 32'(ex_branch), 32'd0);
    chk("fl_ex_aluop_bubble", 32'(ex_aluop), 32'd0);
    chk("fl_mem_memread", 32'(mem_memread), 32'd1);
    chk("fl_ifid_flush_clear", 32'(ifid_flush), 32'd0);

    // Two more load-use stalls and one standalone flush, for the counter totals.
    drain();
    load_use_seq(5'd5);
    load_use_seq(5'd7);
    ex_br_taken = 1'b1;
    tick();
    idle();
    settle();
`ifdef PIPE_PERF_CNT_EN
    chk("cnt_stall_3", stall_cnt, 32'd3);
    chk("cnt_flush_2", flush_cnt, 32'd2);
`endif

    // Forwarding priority: MEM and WB both write x7, and EX reads x7 on both operands.
    drain();
    set_id(1'b1, C_RW, 5'd1, 5'd2, 5'd7);
    tick();
    set_id(1'b1, C_RW, 5'd0, 5'd0, 5'd7);
    tick();
    set_id(1'b1, C_ADD, 5'd7, 5'd7, 5'd8);
    tick();
    idle();
    settle();
    chk("fp_fwd_a_mem", 32'(fwd_a), 32'd2);
    chk("fp_fwd_b_mem", 32'(fwd_b), 32'd2);

    // Same shape, but the MEM instruction is a store, so WB is the source.
    drain();
    set_id(1'b1, C_RW, 5'd1, 5'd2, 5'd7);
    tick();
    set_id(1'b1, C_SW, 5'd0, 5'd0, 5'd7);
    tick();
    set_id(1'b1, C_ADD, 5'd7, 5'd7, 5'd8);
    tick();
    idle();
    settle();
    chk("fp_fwd_a_wb", 32'(fwd_a), 32'd1);
    chk("fp_fwd_b_wb", 32'(fwd_b), 32'd1);
    chk("fp_mem_memwrite", 32'(mem_memwrite), 32'd1);

    // Writes to x0 are never forwarded.
    drain();
    set_id(1'b1, C_RW, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, C_RW, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd8);
    tick();
    idle();
    settle();
    chk("fx0_fwd_a", 32'(fwd_a), 32'd0);
    chk("fx0_fwd_b", 32'(fwd_b), 32'd0);

    // Reset asserted in the middle of a stall clears the hazard.
    drain();
    set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd9);
    tick();
    set_id(1'b1, C_ADD, 5'd9, 5'd0, 5'd6);
    settle();
    chk("mr_pc_write_stall", 32'(pc_write), 32'd0);
    reset = 1'b0;
    tick();
    chk("mr_pc_write_cleared", 32'(pc_write), 32'd1);
    chk("mr_mem_memread", 32'(mem_memread), 32'd0);
    chk("mr_ex_alusrc", 32'(ex_alusrc), 32'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("mr_stall_cnt", stall_cnt, 32'd0);
    chk("mr_flush_cnt", flush_cnt, 32'd0);
`endif
    reset = 1'b1;
    idle();
    tick();
    chk("mr_pc_write_after", 32'(pc_write), 32'd1);
`ifdef PIPE_PERF_CNT_EN
    chk("mr_stall_cnt_after", stall_cnt, 32'd0);
`endif

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
